// File: rtl/mac_address_table.sv
// MAC learning/lookup table: 2-way set-associative hashed storage with a
// 2-cycle registered lookup pipeline, write bypass and a flush sweep.
// Optional entry aging is enabled by defining MAC_TABLE_AGING_EN.
module mac_address_table #(
    parameter int unsigned TABLE_ROWS      = 1024,
    parameter int unsigned NUM_PORTS       = 28
`ifdef MAC_TABLE_AGING_EN
    ,
    parameter int unsigned AGE_TICK_CYCLES = 156250000,
    parameter int unsigned MAX_AGE         = 5
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mac_lookup_en,
    input  logic [11:0] mac_lookup_src_vlan,
    input  logic [47:0] mac_lookup_src_mac,
    input  logic [4:0]  mac_lookup_src_port,
    input  logic [47:0] mac_lookup_dst_mac,
    output logic        mac_lookup_hit,
    output logic [4:0]  mac_lookup_dst_port,
    input  logic        flush_en,
    output logic        flush_busy
);

    localparam int unsigned ROW_BITS    = $clog2(TABLE_ROWS);
    localparam int unsigned KEY_BITS    = 60;
    localparam int unsigned HASH_CHUNKS = (KEY_BITS + ROW_BITS - 1) / ROW_BITS;
    localparam int unsigned PAD_BITS    = HASH_CHUNKS * ROW_BITS;
    localparam int unsigned NUM_WAYS    = 2;
`ifdef MAC_TABLE_AGING_EN
    localparam int unsigned TICK_W      = (AGE_TICK_CYCLES > 1) ? $clog2(AGE_TICK_CYCLES) : 1;
`endif

    typedef struct packed {
        logic        valid;
        logic [11:0] vlan;
        logic [47:0] mac;
        logic [4:0]  port;
`ifdef MAC_TABLE_AGING_EN
        logic [7:0]  epoch;
`endif
    } entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // XOR-fold of the zero-padded {vlan, mac} key into one row index
    function automatic logic [ROW_BITS-1:0] hash_key(input logic [11:0] vlan,
                                                     input logic [47:0] mac);
        logic [PAD_BITS-1:0] key;
        logic [ROW_BITS-1:0] h;
        key = PAD_BITS'({vlan, mac});
        h   = '0;
        for (int i = 0; i < int'(HASH_CHUNKS); i++) begin
            h ^= key[i*ROW_BITS +: ROW_BITS];
        end
        return h;
    endfunction

    state_t              state;
    state_t              state_next;
    logic                flush_we;
    logic [ROW_BITS-1:0] flush_row;

    logic [ROW_BITS-1:0] src_row;
    logic [ROW_BITS-1:0] dst_row;

    entry_t              mem [NUM_WAYS][TABLE_ROWS];
    entry_t              src_rd [NUM_WAYS];
    entry_t              dst_rd [NUM_WAYS];
    entry_t              src_ent [NUM_WAYS];
    entry_t              dst_ent [NUM_WAYS];

    logic                s1_valid;
    logic                s1_kill;
    logic [11:0]         s1_vlan;
    logic [47:0]         s1_src_mac;
    logic [4:0]          s1_src_port;
    logic [47:0]         s1_dst_mac;
    logic [ROW_BITS-1:0] s1_src_row;
    logic [ROW_BITS-1:0] s1_dst_row;

    logic                s2_we;
    logic                s2_way;
    logic [ROW_BITS-1:0] s2_row;
    entry_t              s2_entry;

    logic [NUM_WAYS-1:0] src_live;
    logic [NUM_WAYS-1:0] src_match;
    logic [NUM_WAYS-1:0] dst_match;
    logic                hit_s1;
    logic [4:0]          port_s1;
    logic                learn_ok;
    logic                learn_way;
    logic                evict;
    logic                victim;
    entry_t              learn_entry;
    logic                learn_we;
    logic                evict_we;

`ifdef MAC_TABLE_AGING_EN
    logic [TICK_W-1:0]   tick_cnt;
    logic [7:0]          epoch;
    logic [7:0]          age0;
    logic [7:0]          age1;

    function automatic logic is_live(input entry_t e, input logic [7:0] now);
        return e.valid && (8'(now - e.epoch) <= 8'(MAX_AGE));
    endfunction

    // Free-running epoch timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            epoch    <= '0;
        end else if (tick_cnt == TICK_W'(AGE_TICK_CYCLES - 1)) begin
            tick_cnt <= '0;
            epoch    <= epoch + 8'd1;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign age0   = 8'(epoch - src_ent[0].epoch);
    assign age1   = 8'(epoch - src_ent[1].epoch);
    assign victim = (age1 > age0);
`else
    logic toggle;

    function automatic logic is_live(input entry_t e);
        return e.valid;
    endfunction

    // Round-robin victim pointer, advanced on each eviction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggle <= 1'b0;
        end else if (evict_we) begin
            toggle <= ~toggle;
        end
    end

    assign victim = toggle;
`endif

    assign src_row = hash_key(mac_lookup_src_vlan, mac_lookup_src_mac);
    assign dst_row = hash_key(mac_lookup_src_vlan, mac_lookup_dst_mac);

    // Flush FSM state register and sweep row counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            flush_row  <= '0;
            flush_busy <= 1'b0;
        end else begin
            state      <= state_next;
            flush_busy <= (state_next == FLUSH);
            if (state == FLUSH && !flush_en) begin
                flush_row <= flush_row + 1'b1;
            end else begin
                flush_row <= '0;
            end
        end
    end

    // Flush FSM next state; a new flush_en restarts the sweep
    always_comb begin
        state_next = state;
        flush_we   = 1'b0;
        case (state)
            RUN: begin
                if (flush_en) state_next = FLUSH;
            end
            FLUSH: begin
                flush_we = 1'b1;
                if (flush_en) begin
                    state_next = FLUSH;
                end else if (flush_row == ROW_BITS'(TABLE_ROWS - 1)) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // Table storage: flush/learn writes and registered row reads
    always_ff @(posedge clk) begin
        if (flush_we) begin
            for (int w = 0; w < int'(NUM_WAYS); w++) begin
                mem[w][flush_row] <= '0;
            end
        end
        if (learn_we) begin
            mem[learn_way][s1_src_row] <= learn_entry;
        end
        for (int w = 0; w < int'(NUM_WAYS); w++) begin
            src_rd[w] <= mem[w][src_row];
            dst_rd[w] <= mem[w][dst_row];
        end
    end

    // S0: capture request alongside the RAM read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_kill     <= 1'b0;
            s1_vlan     <= '0;
            s1_src_mac  <= '0;
            s1_src_port <= '0;
            s1_dst_mac  <= '0;
            s1_src_row  <= '0;
            s1_dst_row  <= '0;
        end else begin
            s1_valid    <= mac_lookup_en;
            s1_kill     <= (state == FLUSH);
            s1_vlan     <= mac_lookup_src_vlan;
            s1_src_mac  <= mac_lookup_src_mac;
            s1_src_port <= mac_lookup_src_port;
            s1_dst_mac  <= mac_lookup_dst_mac;
            s1_src_row  <= src_row;
            s1_dst_row  <= dst_row;
        end
    end

    // S1 bypass: the write committed on the same edge as our read is not in the RAM data
    always_comb begin
        for (int w = 0; w < int'(NUM_WAYS); w++) begin
            src_ent[w] = src_rd[w];
            dst_ent[w] = dst_rd[w];
            if (s2_we && s2_way == 1'(w) && s2_row == s1_src_row) src_ent[w] = s2_entry;
            if (s2_we && s2_way == 1'(w) && s2_row == s1_dst_row) dst_ent[w] = s2_entry;
        end
    end

    // S1 compare: per-way liveness and key matches
    always_comb begin
        src_live  = '0;
        src_match = '0;
        dst_match = '0;
        for (int w = 0; w < int'(NUM_WAYS); w++) begin
`ifdef MAC_TABLE_AGING_EN
            src_live[w]  = is_live(src_ent[w], epoch);
            dst_match[w] = is_live(dst_ent[w], epoch) &&
                           dst_ent[w].vlan == s1_vlan && dst_ent[w].mac == s1_dst_mac;
`else
            src_live[w]  = is_live(src_ent[w]);
            dst_match[w] = is_live(dst_ent[w]) &&
                           dst_ent[w].vlan == s1_vlan && dst_ent[w].mac == s1_dst_mac;
`endif
            src_match[w] = src_live[w] &&
                           src_ent[w].vlan == s1_vlan && src_ent[w].mac == s1_src_mac;
        end
        hit_s1  = s1_valid && !s1_kill && !s1_dst_mac[40] && (|dst_match);
        port_s1 = dst_match[0] ? dst_ent[0].port : dst_ent[1].port;
    end

    // S1 merge: choose the way to learn into and build the new entry
    always_comb begin
        learn_way         = 1'b0;
        evict             = 1'b0;
        learn_entry       = '0;
        learn_entry.valid = 1'b1;
        learn_entry.vlan  = s1_vlan;
        learn_entry.mac   = s1_src_mac;
        learn_entry.port  = s1_src_port;
`ifdef MAC_TABLE_AGING_EN
        learn_entry.epoch = epoch;
`endif
        learn_ok = s1_valid && !s1_kill && (state == RUN) && !s1_src_mac[40] &&
                   (32'(s1_src_port) < NUM_PORTS);
        if (src_match[0]) begin
            learn_way = 1'b0;
        end else if (src_match[1]) begin
            learn_way = 1'b1;
        end else if (!src_live[0]) begin
            learn_way = 1'b0;
        end else if (!src_live[1]) begin
            learn_way = 1'b1;
        end else begin
            evict     = 1'b1;
            learn_way = victim;
        end
    end

    assign learn_we = learn_ok;
    assign evict_we = learn_ok && evict;

    // S2: result registers and the write record used for bypass
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_we               <= 1'b0;
            s2_way              <= 1'b0;
            s2_row              <= '0;
            s2_entry            <= '0;
            mac_lookup_hit      <= 1'b0;
            mac_lookup_dst_port <= '0;
        end else begin
            s2_we    <= learn_we;
            s2_way   <= learn_way;
            s2_row   <= s1_src_row;
            s2_entry <= learn_entry;
            if (s1_valid) begin
                mac_lookup_hit      <= hit_s1;
                mac_lookup_dst_port <= hit_s1 ? port_s1 : 5'd0;
            end
        end
    end

endmodule

// File: tb/tb_mac_address_table.sv
// Directed bench for mac_address_table: vector table streamed back-to-back,
// plus flush, restart, reset-during-flush and (aging build) expiry sequences.
module tb_mac_address_table;

    typedef struct {
        logic [11:0] vlan;
        logic [47:0] src;
        logic [4:0]  sport;
        logic [47:0] dst;
        logic        hit;
        logic [4:0]  port;
    } vec_t;

    localparam int NV = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [11:0] vlan;
    logic [47:0] src_mac;
    logic [4:0]  src_port;
    logic [47:0] dst_mac;
    logic        hit;
    logic [4:0]  dst_port;
    logic        flush_en;
    logic        flush_busy;

    int checks = 0;
    int fails  = 0;

    vec_t vecs [NV];

    localparam logic [47:0] A1   = 48'haa00_0000_0001;
    localparam logic [47:0] M10  = 48'h0200_0000_0010;
    localparam logic [47:0] BC   = 48'hffff_ffff_ffff;
    localparam logic [47:0] NOOP = 48'h0200_0000_0099;
    localparam logic [47:0] U77  = 48'h0200_0000_0077;
    localparam logic [47:0] MC   = 48'h0100_5e00_0001;
    localparam logic [47:0] C1   = 48'h0000_0000_0001;
    localparam logic [47:0] C2   = 48'h0000_0000_0400;
    localparam logic [47:0] C3   = 48'h0000_0010_0000;

    always #5 clk = ~clk;

`ifdef MAC_TABLE_AGING_EN
    mac_address_table #(.TABLE_ROWS(1024), .NUM_PORTS(28), .AGE_TICK_CYCLES(10), .MAX_AGE(2)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .mac_lookup_en       (en),
        .mac_lookup_src_vlan (vlan),
        .mac_lookup_src_mac  (src_mac),
        .mac_lookup_src_port (src_port),
        .mac_lookup_dst_mac  (dst_mac),
        .mac_lookup_hit      (hit),
        .mac_lookup_dst_port (dst_port),
        .flush_en            (flush_en),
        .flush_busy          (flush_busy)
    );
`else
    mac_address_table #(.TABLE_ROWS(1024), .NUM_PORTS(28)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .mac_lookup_en       (en),
        .mac_lookup_src_vlan (vlan),
        .mac_lookup_src_mac  (src_mac),
        .mac_lookup_src_port (src_port),
        .mac_lookup_dst_mac  (dst_mac),
        .mac_lookup_hit      (hit),
        .mac_lookup_dst_port (dst_port),
        .flush_en            (flush_en),
        .flush_busy          (flush_busy)
    );
`endif

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic [11:0] v, input logic [47:0] s,
                         input logic [4:0] p, input logic [47:0] d);
        en       = e;
        vlan     = v;
        src_mac  = s;
        src_port = p;
        dst_mac  = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            drive(1'b0, 12'd0, 48'd0, 5'd0, 48'd0);
        end
    endtask

    // Single request, result checked two cycles later
    task automatic one_req(input string name, input logic [11:0] v, input logic [47:0] s,
                           input logic [4:0] p, input logic [47:0] d,
                           input logic exp_hit, input logic [4:0] exp_port);
        @(negedge clk);
        drive(1'b1, v, s, p, d);
        @(negedge clk);
        drive(1'b0, 12'd0, 48'd0, 5'd0, 48'd0);
        @(negedge clk);
        check({name, "_hit"}, 48'(hit), 48'(exp_hit));
        if (exp_hit) check({name, "_port"}, 48'(dst_port), 48'(exp_port));
    endtask

    // Flush with optional restart and optional lookup traffic against learned A1
    task automatic run_flush(input string name, input int restart_at, input int exp_cycles,
                             input logic traffic);
        int         cnt;
        int         bad;
        logic [1:0] pipe;
        cnt  = 0;
        bad  = 0;
        pipe = 2'b00;
        @(negedge clk);
        flush_en = 1'b1;
        if (traffic) drive(1'b1, 12'd5, NOOP, 5'd31, A1);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            flush_en = 1'b0;
            if (pipe[1] && hit !== 1'b0) bad++;
            pipe = {pipe[0], 1'b0};
            if (flush_busy) begin
                cnt++;
                if (cnt == restart_at) flush_en = 1'b1;
                if (traffic) begin
                    drive(1'b1, 12'd5, NOOP, 5'd31, A1);
                    pipe[0] = 1'b1;
                end else begin
                    drive(1'b0, 12'd0, 48'd0, 5'd0, 48'd0);
                end
            end else begin
                drive(1'b0, 12'd0, 48'd0, 5'd0, 48'd0);
                if (pipe == 2'b00) break;
            end
        end
        check({name, "_busy_cycles"}, 48'(cnt), 48'(exp_cycles));
        if (traffic) check({name, "_hits_during_flush"}, 48'(bad), 48'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{12'd5, A1,   5'd3,  A1,   1'b0, 5'd0};
        vecs[1]  = '{12'd5, A1,   5'd3,  A1,   1'b1, 5'd3};
        vecs[2]  = '{12'd5, M10,  5'd4,  BC,   1'b0, 5'd0};
        vecs[3]  = '{12'd5, NOOP, 5'd31, M10,  1'b1, 5'd4};
        vecs[4]  = '{12'd6, NOOP, 5'd31, M10,  1'b0, 5'd0};
        vecs[5]  = '{12'd5, U77,  5'd28, BC,   1'b0, 5'd0};
        vecs[6]  = '{12'd5, MC,   5'd5,  U77,  1'b0, 5'd0};
        vecs[7]  = '{12'd5, NOOP, 5'd31, MC,   1'b0, 5'd0};
        vecs[8]  = '{12'd5, C1,   5'd1,  BC,   1'b0, 5'd0};
        vecs[9]  = '{12'd5, C2,   5'd2,  BC,   1'b0, 5'd0};
        vecs[10] = '{12'd5, C3,   5'd3,  BC,   1'b0, 5'd0};
        vecs[11] = '{12'd5, NOOP, 5'd31, C1,   1'b0, 5'd0};
        vecs[12] = '{12'd5, NOOP, 5'd31, C2,   1'b1, 5'd2};
        vecs[13] = '{12'd5, NOOP, 5'd31, C3,   1'b1, 5'd3};
        vecs[14] = '{12'd5, NOOP, 5'd31, A1,   1'b1, 5'd3};
        vecs[15] = '{12'd5, NOOP, 5'd31, M10,  1'b1, 5'd4};

        rst_n    = 1'b0;
        flush_en = 1'b0;
        drive(1'b0, 12'd0, 48'd0, 5'd0, 48'd0);
        repeat (3) @(negedge clk);
        check("reset_hit", 48'(hit), 48'd0);
        check("reset_port", 48'(dst_port), 48'd0);
        check("reset_busy", 48'(flush_busy), 48'd0);
        rst_n = 1'b1;

        run_flush("flush_init", 0, 1024, 1'b0);

        // Back-to-back stream: result of vector k-2 is visible while vector k is driven
        for (int k = 0; k < NV + 2; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                check($sformatf("vec%0d_hit", k - 2), 48'(hit), 48'(vecs[k-2].hit));
                if (vecs[k-2].hit)
                    check($sformatf("vec%0d_port", k - 2), 48'(dst_port), 48'(vecs[k-2].port));
            end
            if (k < NV) drive(1'b1, vecs[k].vlan, vecs[k].src, vecs[k].sport, vecs[k].dst);
            else        drive(1'b0, 12'd0, 48'd0, 5'd0, 48'd0);
        end

        run_flush("flush_traffic", 0, 1024, 1'b1);
        one_req("post_flush_a1", 12'd5, NOOP, 5'd31, A1, 1'b0, 5'd0);
        one_req("post_flush_m10", 12'd5, NOOP, 5'd31, M10, 1'b0, 5'd0);

        run_flush("flush_restart", 100, 1124, 1'b0);

        // Reset during a sweep returns the FSM to RUN at once
        @(negedge clk);
        flush_en = 1'b1;
        @(negedge clk);
        flush_en = 1'b0;
        repeat (5) @(negedge clk);
        check("midflush_busy_before_reset", 48'(flush_busy), 48'd1);
        rst_n = 1'b0;
        #1;
        check("midflush_reset_busy", 48'(flush_busy), 48'd0);
        check("midflush_reset_hit", 48'(hit), 48'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_flush("flush_after_reset", 0, 1024, 1'b0);
        one_req("learn_after_reset", 12'd7, C1, 5'd9, BC, 1'b0, 5'd0);
        one_req("lookup_after_reset", 12'd7, NOOP, 5'd31, C1, 1'b1, 5'd9);

`ifdef MAC_TABLE_AGING_EN
        run_flush("flush_aging", 0, 1024, 1'b0);
        one_req("age_learn_x", 12'd3, C1, 5'd1, BC, 1'b0, 5'd0);
        one_req("age_learn_y", 12'd3, C2, 5'd2, BC, 1'b0, 5'd0);
        idle(17);
        one_req("age_refresh_y", 12'd3, C2, 5'd2, BC, 1'b0, 5'd0);
        idle(14);
        one_req("age_expired_x", 12'd3, NOOP, 5'd31, C1, 1'b0, 5'd0);
        one_req("age_fresh_y", 12'd3, NOOP, 5'd31, C2, 1'b1, 5'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
